// File: rtl/iir_output_decimator.sv
// -----------------------------------------------------------------------------
// iir_output_decimator
//
// Consumer end of the IIR low-pass filter path. The block takes one filter
// output sample per clock. After enable it discards a warm-up interval while
// the filter settles. It then block-averages DECIM = 2**LOG2_DECIM consecutive
// samples into one output word. Averaged words are queued in a small
// first-word-fall-through FIFO and offered on a valid/ready stream.
//
// Optional feature, selected by the macro IIR_DECIM_ROUND_EN:
//   defined   : round-half-up, (sum + 2**(LOG2_DECIM-1)) >>> LOG2_DECIM,
//               saturated to the positive limit of the DATA_W signed range
//   undefined : truncating arithmetic shift, sum >>> LOG2_DECIM
//
// Ports
//   clk        in   system clock, which is also the filter sample clock
//   reset      in   synchronous, active-high reset
//   en         in   run enable; low returns the averager to IDLE
//   y_in       in   signed filter output sample, valid every cycle
//   m_tdata    out  signed averaged word (0 while the FIFO is empty)
//   m_tvalid   out  m_tdata valid (FIFO not empty)
//   m_tready   in   downstream accept; transfer on m_tvalid & m_tready
//   clr_ovf    in   clears the overflow flag (a new drop on the same cycle wins)
//   overflow   out  sticky: a word was dropped because the FIFO was full
//   fifo_level out  current FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module iir_output_decimator #(
  parameter int DATA_W        = 16,
  parameter int LOG2_DECIM    = 6,
  parameter int SETTLE_CYCLES = 256,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic signed [DATA_W-1:0]        y_in,
  output logic signed [DATA_W-1:0]        m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  input  logic                            clr_ovf,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int DECIM = 1 << LOG2_DECIM;
  // The accumulator holds the sum of DECIM samples, so it cannot overflow.
  localparam int ACC_W = DATA_W + LOG2_DECIM;
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [SET_W-1:0] SET_LAST =
    (SETTLE_CYCLES > 0) ? SET_W'(SETTLE_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ACCUM  = 2'd2;

  logic [1:0]              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [SET_W-1:0]        r_settle;

  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_word;
  logic                     w_last;
  logic                     w_push;

  // The size cast of a signed operand sign-extends the sample into the
  // accumulator width.
  assign w_sum  = r_acc + ACC_W'(y_in);
  assign w_last = (r_cnt == CNT_LAST);
  // A push happens only on the terminal accumulate cycle of a live run.
  // Dropping en on that cycle discards the block.
  assign w_push = en && (r_state == ST_ACCUM) && w_last;

`ifdef IIR_DECIM_ROUND_EN
  localparam int RND_INT = (LOG2_DECIM > 0) ? (1 << (LOG2_DECIM - 1)) : 0;
  localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(RND_INT);
  localparam logic signed [ACC_W:0] W_MAX    =
    {{(LOG2_DECIM + 2){1'b0}}, {(DATA_W - 1){1'b1}}};

  logic signed [ACC_W:0] w_biased;
  logic signed [ACC_W:0] w_rnd;

  // One extra bit of headroom so that the bias cannot wrap a full-scale sum.
  assign w_biased = (ACC_W + 1)'(w_sum) + RND_BIAS;
  assign w_rnd    = w_biased >>> LOG2_DECIM;
  // The bias is positive, so only the positive limit can be exceeded.
  assign w_word   = (w_rnd > W_MAX) ? DATA_W'(W_MAX) : DATA_W'(w_rnd);
`else
  // The arithmetic shift rounds toward -inf. The average of DATA_W-bit samples
  // always fits in DATA_W bits, so the upper bits can be dropped.
  assign w_word = DATA_W'(w_sum >>> LOG2_DECIM);
`endif

  // ---------------------------------------------------------------------------
  // Settle / accumulate control
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values, independent of the order of the blocks.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= (SETTLE_CYCLES == 0) ? ST_ACCUM : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle == SET_LAST) begin
            r_settle <= '0;
            r_state  <= ST_ACCUM;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_ACCUM: begin
          // The terminal sample is folded into w_word, not into r_acc.
          // The next block therefore starts on the very next cycle.
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic                     r_ovf;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop  = m_tvalid && m_tready;
  // A pop on a full FIFO frees the slot that the push reuses on the same edge.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // NOTE: the storage array is not reset. Occupancy is tracked by the reset
  // pointers and level, and the output word is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop on the same cycle as clr_ovf takes priority, so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign m_tvalid   = (r_level != '0);
  assign m_tdata    = m_tvalid ? r_mem[r_rd_ptr] : '0;
  assign overflow   = r_ovf;
  assign fifo_level = r_level;

endmodule
